// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: keyboard reply bytes and the command sequencer state encoding.
package ps2_pkg;

  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_CMD,
    SEND_ARG,
    WAIT_ARG,
    FINISH
  } state_t;

endpackage

// File: rtl/ps2_timeout_counter.sv
// Reply-wait timer: counts enabled cycles and flags the cycle in which the
// count reaches TIMEOUT_CYCLES-1. Saturates at that value instead of wrapping.
module ps2_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_inc;

  assign count_inc = (count == LIMIT) ? count : count + WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

  // Flag the cycle whose edge makes the count reach the limit, so the owner
  // leaves its wait state on that same edge.
  assign expired = enable && !clear && (count_inc == LIMIT);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Sends a PS/2 keyboard command (plus optional argument byte), handles ACK/RESEND
// replies with bounded retries and a reply timeout, and forwards unrelated bytes.
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] req_cmd,
  input  logic       req_has_arg,
  input  logic [7:0] req_arg,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] cmd_out,
  output logic       cmd_send,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pass_data,
  output logic       pass_valid
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  state_t state;
  state_t state_next;

  logic [7:0]         cmd_q;
  logic [7:0]         arg_q;
  logic               has_arg_q;
  logic [RETRY_W-1:0] retry_cnt;
  logic               err_pending;

  logic accept;
  logic retry_inc;
  logic retry_clr;
  logic fail_set;
  logic forward;
  logic in_wait;
  logic tmo_clear;
  logic expired;

  assign in_wait   = (state == WAIT_CMD) || (state == WAIT_ARG);
  assign tmo_clear = !in_wait;
  assign busy      = (state != IDLE);

  ps2_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (in_wait),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= 8'h00;
      arg_q       <= 8'h00;
      has_arg_q   <= 1'b0;
      retry_cnt   <= '0;
      err_pending <= 1'b0;
      pass_valid  <= 1'b0;
      pass_data   <= 8'h00;
    end else begin
      if (accept) begin
        cmd_q     <= req_cmd;
        arg_q     <= req_arg;
        has_arg_q <= req_has_arg;
        retry_cnt <= '0;
      end else if (retry_clr) begin
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + RETRY_W'(1);
      end
      // Only ever set on the edge that enters FINISH, so it is valid there.
      err_pending <= fail_set;
      pass_valid  <= forward;
      if (forward) begin
        pass_data <= rx_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    fail_set   = 1'b0;
    forward    = 1'b0;
    cmd_out    = 8'h00;
    cmd_send   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state)
      IDLE: begin
        forward = rx_valid;
        if (req) begin
          accept     = 1'b1;
          state_next = SEND_CMD;
        end
      end

      SEND_CMD: begin
        cmd_out    = cmd_q;
        cmd_send   = 1'b1;
        forward    = rx_valid;
        state_next = WAIT_CMD;
      end

      SEND_ARG: begin
        cmd_out    = arg_q;
        cmd_send   = 1'b1;
        forward    = rx_valid;
        state_next = WAIT_ARG;
      end

      // Any received byte outranks a timeout landing in the same cycle.
      WAIT_CMD, WAIT_ARG: begin
        if (rx_valid && rx_data == ACK) begin
          retry_clr  = 1'b1;
          state_next = (state == WAIT_CMD && has_arg_q) ? SEND_ARG : FINISH;
        end else if (rx_valid && rx_data == RESEND) begin
          if (retry_cnt == RETRY_LIMIT) begin
            fail_set   = 1'b1;
            state_next = FINISH;
          end else begin
            retry_inc  = 1'b1;
            state_next = (state == WAIT_CMD) ? SEND_CMD : SEND_ARG;
          end
        end else if (rx_valid) begin
          forward = 1'b1;
        end else if (expired) begin
          fail_set   = 1'b1;
          state_next = FINISH;
        end
      end

      FINISH: begin
        done       = !err_pending;
        err        = err_pending;
        forward    = rx_valid;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Self-checking bench for ps2_cmd_sequencer: table of command transactions with
// scripted keyboard replies, plus hand-written reset, timeout and ignored-request cases.
module tb_ps2_cmd_sequencer;

  localparam int TIMEOUT   = 100;
  localparam int MAX_RETRY = 3;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [7:0] req_cmd;
  logic       req_has_arg;
  logic [7:0] req_arg;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] cmd_out;
  logic       cmd_send;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pass_data;
  logic       pass_valid;

  ps2_cmd_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_cmd    (req_cmd),
    .req_has_arg(req_has_arg),
    .req_arg    (req_arg),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cmd_out    (cmd_out),
    .cmd_send   (cmd_send),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pass_data  (pass_data),
    .pass_valid (pass_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event log, sampled on the falling edge away from state updates.
  int         cycle           = 0;
  int         done_cnt        = 0;
  int         err_cnt         = 0;
  int         consec_sends    = 0;
  int         last_send_cycle = 0;
  int         last_err_cycle  = 0;
  logic       prev_send       = 1'b0;
  logic [7:0] sent_q[$];
  logic [7:0] pass_q[$];

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (cmd_send) begin
      sent_q.push_back(cmd_out);
      last_send_cycle = cycle;
      if (prev_send) consec_sends = consec_sends + 1;
    end
    prev_send = cmd_send;
    if (done) done_cnt = done_cnt + 1;
    if (err) begin
      err_cnt        = err_cnt + 1;
      last_err_cycle = cycle;
    end
    if (pass_valid) pass_q.push_back(pass_data);
  end

  typedef struct packed {
    logic [7:0]  cmd;
    logic        has_arg;
    logic [7:0]  arg;
    logic [3:0]  n_rep;
    logic [47:0] rep;
    logic [3:0]  n_send;
    logic [47:0] sends;
    logic        exp_done;
  } vec_t;

  vec_t vecs[8];
  int   nvec = 0;

  function automatic logic [47:0] b6(input logic [7:0] a0, input logic [7:0] a1,
                                     input logic [7:0] a2, input logic [7:0] a3,
                                     input logic [7:0] a4, input logic [7:0] a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic add_vec(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg,
                         input int n_rep, input logic [47:0] rep,
                         input int n_send, input logic [47:0] sends, input logic exp_done);
    vecs[nvec].cmd      = cmd;
    vecs[nvec].has_arg  = has_arg;
    vecs[nvec].arg      = arg;
    vecs[nvec].n_rep    = 4'(n_rep);
    vecs[nvec].rep      = rep;
    vecs[nvec].n_send   = 4'(n_send);
    vecs[nvec].sends    = sends;
    vecs[nvec].exp_done = exp_done;
    nvec = nvec + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_sends(input int target);
    int budget = 300;
    while (sent_q.size() < target && budget > 0) begin
      tick();
      budget = budget - 1;
    end
    checkOutput("cmd_send_seen", int'(sent_q.size() >= target), 1);
  endtask

  task automatic wait_finish(input int bd, input int be);
    int budget = 300;
    while (done_cnt == bd && err_cnt == be && budget > 0) begin
      tick();
      budget = budget - 1;
    end
    checkOutput("finish_seen", int'(done_cnt != bd || err_cnt != be), 1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_req(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg);
    req_cmd     = cmd;
    req_has_arg = has_arg;
    req_arg     = arg;
    req         = 1'b1;
    tick();
    req         = 1'b0;
  endtask

  // Issue one table transaction, answering each cmd_send with the next scripted reply.
  task automatic applyStimulus(input int i);
    int base;
    base = sent_q.size();
    pulse_req(vecs[i].cmd, vecs[i].has_arg, vecs[i].arg);
    for (int k = 0; k < int'(vecs[i].n_rep); k++) begin
      wait_sends(base + k + 1);
      repeat (5) tick();
      send_rx(vecs[i].rep[k*8 +: 8]);
    end
  endtask

  task automatic run_vector(input int i);
    int bs, bd, be, bp;
    bs = sent_q.size();
    bd = done_cnt;
    be = err_cnt;
    bp = pass_q.size();
    applyStimulus(i);
    wait_finish(bd, be);
    tick();
    checkOutput($sformatf("v%0d n_send", i), sent_q.size() - bs, int'(vecs[i].n_send));
    for (int k = 0; k < int'(vecs[i].n_send); k++) begin
      if (bs + k < sent_q.size())
        checkOutput($sformatf("v%0d send[%0d]", i, k), int'(sent_q[bs+k]),
                    int'(vecs[i].sends[k*8 +: 8]));
    end
    checkOutput($sformatf("v%0d done", i), done_cnt - bd, int'(vecs[i].exp_done));
    checkOutput($sformatf("v%0d err", i), err_cnt - be, int'(!vecs[i].exp_done));
    checkOutput($sformatf("v%0d pass", i), pass_q.size() - bp, 0);
    checkOutput($sformatf("v%0d busy_after", i), int'(busy), 0);
  endtask

  initial begin
    int bs, bd, be, bp;

    rst_n       = 1'b0;
    req         = 1'b0;
    req_cmd     = 8'h00;
    req_has_arg = 1'b0;
    req_arg     = 8'h00;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;

    add_vec(8'hF4, 1'b0, 8'h00, 1, b6(8'hFA, 0, 0, 0, 0, 0),
            1, b6(8'hF4, 0, 0, 0, 0, 0), 1'b1);
    add_vec(8'hED, 1'b1, 8'h07, 2, b6(8'hFA, 8'hFA, 0, 0, 0, 0),
            2, b6(8'hED, 8'h07, 0, 0, 0, 0), 1'b1);
    add_vec(8'hED, 1'b1, 8'h07, 4, b6(8'hFE, 8'hFE, 8'hFA, 8'hFA, 0, 0),
            4, b6(8'hED, 8'hED, 8'hED, 8'h07, 0, 0), 1'b1);
    add_vec(8'hED, 1'b1, 8'h07, 4, b6(8'hFE, 8'hFE, 8'hFE, 8'hFE, 0, 0),
            4, b6(8'hED, 8'hED, 8'hED, 8'hED, 0, 0), 1'b0);
    add_vec(8'hF3, 1'b1, 8'h20, 3, b6(8'hFA, 8'hFE, 8'hFA, 0, 0, 0),
            3, b6(8'hF3, 8'h20, 8'h20, 0, 0, 0), 1'b1);
    add_vec(8'hFF, 1'b0, 8'h00, 4, b6(8'hFE, 8'hFE, 8'hFE, 8'hFA, 0, 0),
            4, b6(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0), 1'b1);
    add_vec(8'hED, 1'b1, 8'h02, 5, b6(8'hFA, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 0),
            5, b6(8'hED, 8'h02, 8'h02, 8'h02, 8'h02, 0), 1'b0);
    add_vec(8'hF0, 1'b0, 8'h55, 1, b6(8'hFA, 0, 0, 0, 0, 0),
            1, b6(8'hF0, 0, 0, 0, 0, 0), 1'b1);

    // Outputs while held in reset.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset err", int'(err), 0);
    checkOutput("reset cmd_send", int'(cmd_send), 0);
    checkOutput("reset cmd_out", int'(cmd_out), 0);
    checkOutput("reset pass_valid", int'(pass_valid), 0);
    checkOutput("reset pass_data", int'(pass_data), 0);
    rst_n = 1'b1;
    tick();

    // Idle forwarding, including the reply bytes themselves.
    send_rx(8'hFA);
    checkOutput("idle pass_valid FA", int'(pass_valid), 1);
    checkOutput("idle pass_data FA", int'(pass_data), 8'hFA);
    send_rx(8'hFE);
    checkOutput("idle pass_valid FE", int'(pass_valid), 1);
    checkOutput("idle pass_data FE", int'(pass_data), 8'hFE);
    tick();
    checkOutput("idle pass_valid low", int'(pass_valid), 0);
    checkOutput("idle busy", int'(busy), 0);

    for (int i = 0; i < nvec; i++) run_vector(i);

    // Timeout with an unrelated byte interleaved during WAIT_CMD.
    bs = sent_q.size();
    bd = done_cnt;
    be = err_cnt;
    bp = pass_q.size();
    pulse_req(8'hF2, 1'b0, 8'h00);
    checkOutput("tmo busy", int'(busy), 1);
    wait_sends(bs + 1);
    repeat (10) tick();
    send_rx(8'h1C);
    wait_finish(bd, be);
    tick();
    checkOutput("tmo err", err_cnt - be, 1);
    checkOutput("tmo done", done_cnt - bd, 0);
    checkOutput("tmo sends", sent_q.size() - bs, 1);
    checkOutput("tmo latency", last_err_cycle - last_send_cycle, TIMEOUT);
    checkOutput("tmo pass count", pass_q.size() - bp, 1);
    if (pass_q.size() > bp) checkOutput("tmo pass byte", int'(pass_q[bp]), 8'h1C);

    // Asynchronous reset while waiting for the argument ACK.
    bs = sent_q.size();
    bd = done_cnt;
    be = err_cnt;
    pulse_req(8'hED, 1'b1, 8'h07);
    wait_sends(bs + 1);
    repeat (3) tick();
    send_rx(8'hFA);
    wait_sends(bs + 2);
    repeat (2) tick();
    checkOutput("rst pre busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst cmd_send", int'(cmd_send), 0);
    checkOutput("rst cmd_out", int'(cmd_out), 0);
    checkOutput("rst done", int'(done), 0);
    checkOutput("rst err", int'(err), 0);
    checkOutput("rst pass_valid", int'(pass_valid), 0);
    checkOutput("rst pass_data", int'(pass_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) tick();
    checkOutput("rst no done", done_cnt - bd, 0);
    checkOutput("rst no err", err_cnt - be, 0);
    checkOutput("rst no send", sent_q.size() - bs, 2);
    run_vector(0);

    // Requests while busy and in the FINISH cycle are dropped.
    bs = sent_q.size();
    bd = done_cnt;
    be = err_cnt;
    pulse_req(8'hF4, 1'b0, 8'h00);
    wait_sends(bs + 1);
    pulse_req(8'hAA, 1'b1, 8'h11);
    repeat (3) tick();
    send_rx(8'hFA);
    checkOutput("ign in finish", int'(done), 1);
    pulse_req(8'hBB, 1'b0, 8'h00);
    repeat (15) tick();
    checkOutput("ign sends", sent_q.size() - bs, 1);
    if (sent_q.size() > bs) checkOutput("ign byte", int'(sent_q[bs]), 8'hF4);
    checkOutput("ign done", done_cnt - bd, 1);
    checkOutput("ign err", err_cnt - be, 0);
    checkOutput("ign busy", int'(busy), 0);

    checkOutput("no back-to-back cmd_send", consec_sends, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_cmd_sequencer.md
PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, cycles to wait for a keyboard reply per sent byte (20 ms at 50 MHz).
REQ-002 SHALL have parameter MAX_RETRY, default 3, number of resends allowed per byte after a RESEND reply.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  one-cycle pulse that starts a command transaction.
REQ-006 SHALL have port req_cmd  input  8  command byte, sampled when req is accepted.
REQ-007 SHALL have port req_has_arg  input  1  high when the command carries an argument byte, sampled with req.
REQ-008 SHALL have port req_arg  input  8  argument byte, sampled with req.
REQ-009 SHALL have port busy  output  1  high from the cycle after acceptance until the cycle done or err pulses.
REQ-010 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-011 SHALL have port err  output  1  one-cycle pulse on timeout or retry exhaustion.
REQ-012 SHALL have port cmd_out  output  8  byte to the PS/2 controller.
REQ-013 SHALL have port cmd_send  output  1  one-cycle pulse; cmd_out is valid in the same cycle.
REQ-014 SHALL have port rx_data  input  8  byte received from the PS/2 controller.
REQ-015 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-016 SHALL have port pass_data  output  8  received byte forwarded to the keyboard buffer.
REQ-017 SHALL have port pass_valid  output  1  one-cycle strobe qualifying pass_data.

Function
REQ-018 SHALL implement states IDLE, SEND_CMD, WAIT_CMD, SEND_ARG, WAIT_ARG, FINISH.
REQ-019 SHALL accept req only in IDLE; req in any other state is ignored and not queued.
REQ-020 On acceptance SHALL latch req_cmd, req_has_arg and req_arg, clear the retry count, and enter SEND_CMD.
REQ-021 SEND_CMD SHALL drive cmd_out=cmd and cmd_send=1 for exactly one cycle, clear the timeout counter, and enter WAIT_CMD; SEND_ARG does the same with the argument byte and enters WAIT_ARG.
REQ-022 In WAIT_*, rx_valid with rx_data=0xFA (ACK) SHALL advance: WAIT_CMD goes to SEND_ARG if has_arg, else FINISH; WAIT_ARG goes to FINISH; the retry count clears on each ACK.
REQ-023 In WAIT_*, rx_data=0xFE (RESEND) SHALL return to the matching SEND_* state and increment the retry count; when the count already equals MAX_RETRY it SHALL instead enter FINISH with error.
REQ-024 In WAIT_*, any other received byte SHALL be forwarded on pass_data/pass_valid in the following cycle and SHALL not change state.
REQ-025 In IDLE, every received byte, including 0xFA and 0xFE, SHALL be forwarded with one-cycle latency.
REQ-026 The timeout counter SHALL count cycles in WAIT_*; reaching TIMEOUT_CYCLES-1 with no ACK or RESEND SHALL enter FINISH with error; an rx_valid in that same cycle takes priority over the timeout.
REQ-027 FINISH SHALL pulse exactly one of done or err for one cycle and return to IDLE; a req in the FINISH cycle is ignored.
REQ-028 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES ($clog2) and SHALL saturate, never wrap.
REQ-029 cmd_send SHALL never assert in two consecutive cycles.

Reset
REQ-030 rst_n low SHALL force IDLE immediately, regardless of the clock.
REQ-031 Under reset, busy, done, err, cmd_send and pass_valid SHALL be 0, cmd_out and pass_data 0x00, and the counters 0.
REQ-032 Reset during any transaction SHALL abort it silently: no done or err pulse follows.

Structure
REQ-033 The PS/2 reply constants ACK=0xFA and RESEND=0xFE, and the state encoding, SHALL live in a shared package ps2_pkg.
REQ-034 The timeout counter SHALL be a sub-module ps2_timeout_counter with clear, enable and expired ports; everything else stays flat.

Verification
REQ-035 Basic command: req_cmd=0xF4, has_arg=0, then reply 0xFA five cycles after cmd_send -> one cmd_send with 0xF4, done pulses once, busy drops, no pass_valid.
REQ-036 Command with argument: req_cmd=0xED, req_arg=0x07, two ACKs -> cmd_send 0xED then 0x07, done pulses once.
REQ-037 Resend: reply 0xFE, 0xFE, then 0xFA to 0xED -> 0xED is sent three times and done follows; four 0xFE replies with MAX_RETRY=3 -> err pulses and no argument byte is sent.
REQ-038 Timeout and interleave: TIMEOUT_CYCLES=100, reply 0x1C during WAIT_CMD and nothing else -> pass_data=0x1C forwarded once, err pulses 100 cycles after cmd_send.
REQ-039 Reset mid-op: assert rst_n low in WAIT_ARG -> all outputs 0 asynchronously, no done or err after release, next req works normally.
REQ-040 Ignored request: a second req while busy -> no extra cmd_send, and the original transaction completes unchanged.
